// File: rtl/div_ctrl.sv
// Sequencing controller for the shared 32-bit iterative divider (RISC-V DIV/DIVU/REM/REMU).
// Optional one-entry result cache enabled by defining DIV_CTRL_CACHE_EN.
module div_ctrl #(
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             busy,
  output logic [31:0]      core_dividend,
  output logic [31:0]      core_divisor,
  input  logic [31:0]      core_q,
  input  logic [31:0]      core_r,
  input  logic             core_ready
);

  typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, DONE} state_t;

  state_t      state;
  logic        op_rem;
  logic        neg_q;
  logic        neg_r;

  logic        req_sgn;
  logic        div_zero;
  logic        sgn_ovf;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] special_data;
  logic [31:0] q_fix;
  logic [31:0] r_fix;
  logic        cache_hit;
  logic [31:0] cache_data;
  logic        capture;

  assign req_ready = (state == IDLE);

  always_comb begin
    req_sgn      = ~req_op[0];
    div_zero     = (req_b == '0);
    sgn_ovf      = req_sgn && (req_a == 32'h8000_0000) && (req_b == '1);
    abs_a        = (req_sgn && req_a[31]) ? -req_a : req_a;
    abs_b        = (req_sgn && req_b[31]) ? -req_b : req_b;
    special_data = '0;
    if (div_zero)
      special_data = req_op[1] ? req_a : '1;
    else
      special_data = req_op[1] ? '0 : 32'h8000_0000;
    q_fix   = neg_q ? -core_q : core_q;
    r_fix   = neg_r ? -core_r : core_r;
    capture = (state == BUSY) && !flush && core_ready;
  end

`ifdef DIV_CTRL_CACHE_EN
  logic        cache_valid;
  logic [31:0] cache_a;
  logic [31:0] cache_b;
  logic        cache_sgn;
  logic [31:0] cache_q;
  logic [31:0] cache_r;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        op_sgn;

  always_comb begin
    cache_hit  = cache_valid && (cache_a == req_a) && (cache_b == req_b) && (cache_sgn == req_sgn);
    cache_data = req_op[1] ? cache_r : cache_q;
  end

  // Entries hold sign-corrected results; a hit requires equal operands and signedness,
  // so the correction applied at capture is the one the new request would need.
  always_ff @(posedge clk) begin
    if (reset) begin
      cache_valid <= 1'b0;
      cache_a     <= '0;
      cache_b     <= '0;
      cache_sgn   <= 1'b0;
      cache_q     <= '0;
      cache_r     <= '0;
      op_a        <= '0;
      op_b        <= '0;
      op_sgn      <= 1'b0;
    end else begin
      if (state == IDLE && req_valid && !flush) begin
        op_a   <= req_a;
        op_b   <= req_b;
        op_sgn <= req_sgn;
      end
      if (capture) begin
        cache_valid <= 1'b1;
        cache_a     <= op_a;
        cache_b     <= op_b;
        cache_sgn   <= op_sgn;
        cache_q     <= q_fix;
        cache_r     <= r_fix;
      end
    end
  end
`else
  always_comb begin
    cache_hit  = 1'b0;
    cache_data = '0;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      op_rem        <= 1'b0;
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
      resp_valid    <= 1'b0;
      resp_data     <= '0;
      resp_tag      <= '0;
      busy          <= 1'b0;
      core_dividend <= '0;
      core_divisor  <= '0;
    end else if (flush && state != IDLE) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && !flush) begin
            busy     <= 1'b1;
            op_rem   <= req_op[1];
            neg_q    <= req_sgn && (req_a[31] ^ req_b[31]);
            neg_r    <= req_sgn && req_a[31];
            resp_tag <= req_tag;
            if (div_zero || sgn_ovf) begin
              resp_data  <= special_data;
              resp_valid <= 1'b1;
              state      <= DONE;
            end else if (cache_hit) begin
              resp_data  <= cache_data;
              resp_valid <= 1'b1;
              state      <= DONE;
            end else begin
              core_dividend <= abs_a;
              core_divisor  <= abs_b;
              state         <= LAUNCH;
            end
          end
        end
        LAUNCH: begin
          if (core_ready)
            state <= BUSY;
        end
        BUSY: begin
          if (capture) begin
            resp_data  <= op_rem ? r_fix : q_fix;
            resp_valid <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed self-checking bench for div_ctrl with a behavioural 32-cycle divider core.
// Cache checks run only when DIV_CTRL_CACHE_EN is defined.
module tb_div_ctrl;
  localparam int unsigned TAG_W = 5;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             flush = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [1:0]       req_op = '0;
  logic [31:0]      req_a = '0;
  logic [31:0]      req_b = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic             resp_valid;
  logic             resp_ready = 1'b0;
  logic [31:0]      resp_data;
  logic [TAG_W-1:0] resp_tag;
  logic             busy;
  logic [31:0]      core_dividend;
  logic [31:0]      core_divisor;
  logic [31:0]      core_q;
  logic [31:0]      core_r;
  logic             core_ready = 1'b1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  div_ctrl #(.TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_tag(resp_tag), .busy(busy),
    .core_dividend(core_dividend), .core_divisor(core_divisor),
    .core_q(core_q), .core_r(core_r), .core_ready(core_ready)
  );

  // Core model: loads whenever idle, then stays busy for 32 cycles.
  logic [31:0] ld_a = '0;
  logic [31:0] ld_b = '0;
  int          cnt  = 0;
  always @(posedge clk) begin
    if (core_ready) begin
      ld_a       <= core_dividend;
      ld_b       <= core_divisor;
      cnt        <= 32;
      core_ready <= 1'b0;
    end else begin
      cnt <= cnt - 1;
      if (cnt == 1) core_ready <= 1'b1;
    end
  end
  assign core_q = (ld_b == 0) ? '1   : ld_a / ld_b;
  assign core_r = (ld_b == 0) ? ld_a : ld_a % ld_b;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called from just after a rising edge; returns edges after accept until resp_valid.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] t, input bit ack,
                       output logic [31:0] d, output logic [TAG_W-1:0] rt, output int lat);
    int n;
    n = 0;
    while (!req_ready && n < 200) begin @(posedge clk); #1; n++; end
    if (!req_ready) check("ready_timeout", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = t;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    if (!resp_valid) check("resp_timeout", 32'(resp_valid), 32'd1);
    d  = resp_data;
    rt = resp_tag;
    if (ack) begin
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0]      d;
    logic [TAG_W-1:0] rt;
    logic [31:0]      cd, cv;
    int               lat, cntv, sb;
    bit               launched;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_resp_tag", 32'(resp_tag), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_core_dividend", core_dividend, 32'd0);
    check("rst_core_divisor", core_divisor, 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);

    do_op(2'b01, 32'd100, 32'd7, 5'd3, 1'b1, d, rt, lat);
    check("divu_100_7", d, 32'd14);
    check("divu_tag", 32'(rt), 32'd3);
    check("divu_lat", 32'(lat >= 34 && lat <= 66), 32'd1);

    do_op(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd4, 1'b1, d, rt, lat);
    check("div_m7_2", d, 32'hFFFF_FFFD);

    do_op(2'b11, 32'd100, 32'd7, 5'd17, 1'b1, d, rt, lat);
    check("remu_100_7", d, 32'd2);
    check("remu_tag", 32'(rt), 32'd17);
    check("remu_lat", 32'(lat >= 34 && lat <= 66), 32'd1);

    do_op(2'b10, 32'd7, 32'hFFFF_FFFE, 5'd5, 1'b1, d, rt, lat);
    check("rem_7_m2", d, 32'd1);
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd6, 1'b1, d, rt, lat);
    check("rem_m7_2", d, 32'hFFFF_FFFF);

    // Special cases answer at the accept edge and leave the core operands alone.
    cd = core_dividend; cv = core_divisor;
    do_op(2'b01, 32'd5, 32'd0, 5'd7, 1'b1, d, rt, lat);
    check("divu_5_0", d, 32'hFFFF_FFFF);
    check("divu0_lat", 32'(lat + 1), 32'd1);
    check("divu0_tag", 32'(rt), 32'd7);
    do_op(2'b11, 32'd5, 32'd0, 5'd8, 1'b1, d, rt, lat);
    check("remu_5_0", d, 32'd5);
    do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 1'b1, d, rt, lat);
    check("div_ovf", d, 32'h8000_0000);
    check("ovf_lat", 32'(lat + 1), 32'd1);
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 1'b1, d, rt, lat);
    check("rem_ovf", d, 32'd0);
    check("special_core_dividend", core_dividend, cd);
    check("special_core_divisor", core_divisor, cv);

    // A request presented together with flush in IDLE is refused.
    req_valid = 1'b1; req_op = 2'b01; req_a = 32'd9; req_b = 32'd3; flush = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    check("flush_req_ready", 32'(req_ready), 32'd1);
    check("flush_req_busy", 32'(busy), 32'd0);

    // Flush 10 cycles into BUSY.
    req_valid = 1'b1; req_op = 2'b01; req_a = 32'd1234; req_b = 32'd5; req_tag = 5'd11;
    @(posedge clk); #1;
    req_valid = 1'b0;
    launched = 1'b0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (core_ready) begin launched = 1'b1; break; end
    end
    check("launch_seen", 32'(launched), 32'd1);
    @(posedge clk); #1;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_resp_valid", 32'(resp_valid), 32'd0);
    check("flush_req_ready_after", 32'(req_ready), 32'd1);
    check("flush_busy", 32'(busy), 32'd0);
    cntv = 0;
    repeat (40) begin @(posedge clk); #1; if (resp_valid) cntv++; end
    check("flush_no_resp", 32'(cntv), 32'd0);
    do_op(2'b01, 32'd1000, 32'd10, 5'd12, 1'b1, d, rt, lat);
    check("divu_1000_10", d, 32'd100);
    check("post_flush_lat", 32'(lat >= 34 && lat <= 66), 32'd1);

    // Back-pressure in DONE.
    do_op(2'b01, 32'd77, 32'd7, 5'd21, 1'b0, d, rt, lat);
    check("stall_data", d, 32'd11);
    check("stall_tag", 32'(rt), 32'd21);
    sb = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (!resp_valid || resp_data !== d || resp_tag !== rt || req_ready) sb++;
    end
    check("stall_stable", 32'(sb), 32'd0);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("stall_release_valid", 32'(resp_valid), 32'd0);
    check("stall_release_ready", 32'(req_ready), 32'd1);
    cntv = 0;
    repeat (10) begin @(posedge clk); #1; if (resp_valid) cntv++; end
    check("stall_single_resp", 32'(cntv), 32'd0);

`ifdef DIV_CTRL_CACHE_EN
    do_op(2'b00, 32'd50, 32'hFFFF_FFFD, 5'd13, 1'b1, d, rt, lat);
    check("cache_div_50_m3", d, 32'hFFFF_FFF0);
    check("cache_miss_lat", 32'(lat >= 34 && lat <= 66), 32'd1);
    do_op(2'b10, 32'd50, 32'hFFFF_FFFD, 5'd14, 1'b1, d, rt, lat);
    check("cache_rem_50_m3", d, 32'd2);
    check("cache_hit_lat", 32'(lat + 1), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    do_op(2'b10, 32'd50, 32'hFFFF_FFFD, 5'd15, 1'b1, d, rt, lat);
    check("cache_rst_rem", d, 32'd2);
    check("cache_rst_lat", 32'(lat >= 34 && lat <= 66), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/div_ctrl.md
# div_ctrl

Sequencing controller for the shared 32-bit unsigned iterative divider core in the execute stage. It accepts RISC-V M-extension divide/remainder requests (DIV, DIVU, REM, REMU) over a valid/ready handshake. For normal operands it drives the core and applies sign correction to the result; it answers divide-by-zero and signed overflow directly without using the core. The pipeline stalls on `req_ready`/`resp_valid`, and only one operation is outstanding at a time.

## Interface
- `TAG_W`, default 5: width of the destination-register tag passed through from request to response.

- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `flush` in 1: kill the current operation; no response is produced.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE.
- `req_op` in 2: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `req_a`, `req_b` in 32 each: dividend and divisor.
- `req_tag` in TAG_W: destination tag.
- `resp_valid` out 1: result valid; held until `resp_ready`.
- `resp_ready` in 1: consumer accepts the result.
- `resp_data` out 32: quotient or remainder.
- `resp_tag` out TAG_W: tag of the request.
- `busy` out 1: state is not IDLE.
- `core_dividend`, `core_divisor` out 32 each: unsigned operands to the core, registered.
- `core_q`, `core_r` in 32 each: core results.
- `core_ready` in 1: core idle flag.
  - The core loads operands on every edge where `core_ready`=1.
  - `core_ready` then stays low for 32 cycles.
  - `core_q`/`core_r` are valid in the first cycle `core_ready` is high again.

## Operation
- States: IDLE, LAUNCH, BUSY, DONE.
- Accept happens on an edge with `req_valid` && `req_ready` && !`flush`. At accept, latch op, tag, signedness and operand signs.
  - Divisor 0: result is `0xFFFFFFFF` for DIV/DIVU, `req_a` for REM/REMU. Go to DONE.
  - Signed op with `req_a`=`0x80000000` and `req_b`=`0xFFFFFFFF`: result is `0x80000000` for DIV, 0 for REM. Go to DONE.
  - Otherwise: `core_dividend`/`core_divisor` get |a|/|b| for signed ops, raw a/b for unsigned ops. Go to LAUNCH.
- LAUNCH: on an edge with `core_ready`=1, the core loads; go to BUSY.
- BUSY: on an edge with `core_ready`=1, capture the result and go to DONE.
  - Signed DIV: quotient negated (two's complement) when the operand signs differ.
  - Signed REM: remainder negated when the dividend is negative.
  - Unsigned ops: result taken unmodified.
- DONE: `resp_valid`=1 with `resp_data` and `resp_tag` stable. On an edge with `resp_ready`=1, go to IDLE.
- `flush` (any state other than IDLE): next state IDLE, `resp_valid` drops next cycle, no response.
  - The core is not reset. Its in-flight result is ignored.
  - The next LAUNCH waits for `core_ready`.
- `flush` and `req_valid` in the same cycle: the request is not accepted.
- `reset` at any time: IDLE, in-flight operation discarded, cache invalidated.
- Core results are unsigned 32-bit. Negation wraps modulo 2^32.

## Timing
- Reset values: `resp_valid`=0, `resp_data`=0, `resp_tag`=0, `busy`=0, `core_dividend`=0, `core_divisor`=0. `req_ready`=1 in the first cycle after reset deasserts.
- `req_ready` = (state==IDLE), combinational from the state register.
- Special cases: `resp_valid` rises in the cycle after accept (latency 1).
- Normal ops, with E0 as the accept edge:
  - Minimum: core loads at E1; `core_ready` is low for cycles 2–33; capture at E34; `resp_valid` in cycle 35. Latency 34 edges.
  - Maximum: LAUNCH waits up to 32 more cycles for `core_ready`, giving 66.
- Back-to-back: the earliest next accept is the edge after the response handshake, since IDLE is re-entered then.
- `resp_data` and `resp_tag` remain stable while `resp_valid`=1 && !`resp_ready`.

## Configuration
- `DIV_CTRL_CACHE_EN` defined: one-entry result cache holding {a, b, signed flag, quotient, remainder}.
  - Written at every BUSY capture, storing both quotient and remainder.
  - Invalidated by reset only. `flush` does not write it.
  - A non-special request matching a, b and signedness goes directly to DONE with the cached value (latency 1). Example: REM after DIV with the same operands.
- Undefined: no cache state; every non-special request uses the core.

## Test plan
- DIVU 100/7 -> 14; REMU 100/7 -> 2; each latency within 34–66 edges; `resp_tag` equals `req_tag`.
- DIV `0xFFFFFFF9`(-7)/2 -> `0xFFFFFFFD`; REM -7/2 -> `0xFFFFFFFF`; REM 7/-2 -> 1.
- DIVU 5/0 -> `0xFFFFFFFF` at latency 1; REMU 5/0 -> 5; DIV `0x80000000`/`0xFFFFFFFF` -> `0x80000000`; REM of the same -> 0; core operands unchanged.
- `flush` 10 cycles into BUSY -> no `resp_valid`, `req_ready`=1 next cycle; a following DIVU 1000/10 -> 100.
- `resp_ready` held low 20 cycles in DONE -> `resp_valid`, data and tag stable; `req_ready`=0 throughout; one handshake only.
- With `DIV_CTRL_CACHE_EN`: DIV 50/-3 -> `0xFFFFFFF0` (core used), then REM 50/-3 -> 2 at latency 1; `reset` then REM 50/-3 uses the core again.
